// File: rtl/avalon_mm_burst_mem_slave_if.sv
// rtl/avalon_mm_burst_mem_slave_if.sv - Avalon-MM burst bus bundle with master/slave modports
interface avalon_mm_if #(
   parameter int ADDR_WIDTH        = 32,
   parameter int DATA_WIDTH        = 64,
   parameter int BURST_COUNT_WIDTH = 8,
   parameter int BYTE_ENABLE_WIDTH = DATA_WIDTH / 8
) ();
   logic [ADDR_WIDTH-1:0]        address;
   logic [BURST_COUNT_WIDTH-1:0] burstcount;
   logic [DATA_WIDTH-1:0]        writedata;
   logic [BYTE_ENABLE_WIDTH-1:0] byteenable;
   logic                         write;
   logic                         read;
   logic                         waitrequest;
   logic [DATA_WIDTH-1:0]        readdata;
   logic                         readdatavalid;

   modport master (
      output address, burstcount, writedata, byteenable, write, read,
      input  waitrequest, readdata, readdatavalid
   );

   modport slave (
      input  address, burstcount, writedata, byteenable, write, read,
      output waitrequest, readdata, readdatavalid
   );
endinterface

// File: rtl/avalon_mm_burst_mem_slave.sv
// rtl/avalon_mm_burst_mem_slave.sv - burst memory slave; optional stall injection via AVMM_BURST_MEM_SLAVE_BACKPRESSURE_EN
module avalon_mm_burst_mem_slave #(
   parameter int ADDR_WIDTH        = 32,
   parameter int DATA_WIDTH        = 64,
   parameter int BURST_COUNT_WIDTH = 8,
   parameter int BYTE_ENABLE_WIDTH = DATA_WIDTH / 8,
   parameter int MEM_WORDS_LOG2    = 10,
   parameter int READ_LATENCY      = 2
) (
   input  logic     clk,
   input  logic     rst,
   avalon_mm_if.slave bus
);

   localparam int OFF_BITS = $clog2(BYTE_ENABLE_WIDTH);
   localparam int WORDS    = 1 << MEM_WORDS_LOG2;

   typedef logic [MEM_WORDS_LOG2-1:0]    idx_t;
   typedef logic [BURST_COUNT_WIDTH-1:0] cnt_t;
   typedef enum logic [1:0] {IDLE, WR_BURST, RD_BURST} state_t;

   state_t state_q, state_d;
   idx_t   ptr_q, ptr_d;      // next word of the active burst (write or read)
   cnt_t   rem_q, rem_d;      // beats still to be written / issued

   logic [READ_LATENCY-1:0] vld_q, vld_d;
   logic [DATA_WIDTH-1:0]   dat_q [READ_LATENCY];
   logic [DATA_WIDTH-1:0]   dat_d [READ_LATENCY];

   logic [DATA_WIDTH-1:0] mem [WORDS];

   idx_t                  cmd_idx;
   cnt_t                  cmd_cnt;
   idx_t                  wr_idx;
   logic                  wait_req;
   logic                  wr_acc;
   logic                  rd_acc;
   logic                  issue;
   logic                  inject;
   logic [DATA_WIDTH-1:0] rd_word;
   logic                  unused_addr;

   assign unused_addr = ^bus.address;

`ifdef AVMM_BURST_MEM_SLAVE_BACKPRESSURE_EN
   logic [15:0] lfsr_q, lfsr_d;

   // Fibonacci LFSR (taps 16,14,13,11) producing pseudo-random stall cycles
   always_comb begin
      lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
   end

   // LFSR register, reseeded on every reset
   always_ff @(posedge clk) begin
      if (rst) lfsr_q <= 16'hACE1;
      else     lfsr_q <= lfsr_d;
   end

   assign inject = (lfsr_q[1:0] == 2'b00) && (state_q != RD_BURST);
`else
   assign inject = 1'b0;
`endif

   // Command decode, flow control and the word read at issue time
   always_comb begin
      cmd_idx  = bus.address[MEM_WORDS_LOG2+OFF_BITS-1:OFF_BITS];
      cmd_cnt  = (bus.burstcount == '0) ? cnt_t'(1) : bus.burstcount;
      wait_req = rst | (state_q == RD_BURST) | (bus.read & bus.write)
               | (bus.read & (state_q == WR_BURST)) | inject;
      wr_acc   = bus.write & ~wait_req;
      rd_acc   = bus.read & ~wait_req;
      issue    = (state_q == RD_BURST);
      wr_idx   = (state_q == IDLE) ? cmd_idx : ptr_q;
      rd_word  = mem[ptr_q];
   end

   // Burst sequencing: next state, burst pointer and remaining-beat count
   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      rem_d   = rem_q;
      case (state_q)
         IDLE: begin
            if (wr_acc) begin
               ptr_d = cmd_idx + 1'b1;
               rem_d = cmd_cnt - 1'b1;
               if (cmd_cnt != cnt_t'(1)) state_d = WR_BURST;
            end else if (rd_acc) begin
               ptr_d   = cmd_idx;
               rem_d   = cmd_cnt;
               state_d = RD_BURST;
            end
         end
         WR_BURST: begin
            if (wr_acc) begin
               ptr_d = ptr_q + 1'b1;
               rem_d = rem_q - 1'b1;
               if (rem_q == cnt_t'(1)) state_d = IDLE;
            end
         end
         RD_BURST: begin
            ptr_d = ptr_q + 1'b1;
            rem_d = rem_q - 1'b1;
            if (rem_q == cnt_t'(1)) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // Read-return pipeline; data stages hold when no beat passes through
   always_comb begin
      vld_d[0] = issue;
      dat_d[0] = issue ? rd_word : dat_q[0];
      for (int i = 1; i < READ_LATENCY; i++) begin
         vld_d[i] = vld_q[i-1];
         dat_d[i] = vld_q[i-1] ? dat_q[i-1] : dat_q[i];
      end
   end

   // State and pipeline registers; reset abandons bursts and in-flight beats
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         ptr_q   <= '0;
         rem_q   <= '0;
         vld_q   <= '0;
         for (int i = 0; i < READ_LATENCY; i++) dat_q[i] <= '0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         rem_q   <= rem_d;
         vld_q   <= vld_d;
         for (int i = 0; i < READ_LATENCY; i++) dat_q[i] <= dat_d[i];
      end
   end

   // Byte-masked array write; contents deliberately survive reset
   always_ff @(posedge clk) begin
      if (wr_acc) begin
         for (int b = 0; b < BYTE_ENABLE_WIDTH; b++) begin
            if (bus.byteenable[b]) mem[wr_idx][8*b +: 8] <= bus.writedata[8*b +: 8];
         end
      end
   end

   assign bus.waitrequest   = wait_req;
   assign bus.readdata      = dat_q[READ_LATENCY-1];
   assign bus.readdatavalid = vld_q[READ_LATENCY-1];

endmodule
